// File: rtl/rr_switch_arbiter.sv
// rr_switch_arbiter
//   Round-robin arbiter that shares one grant slot among N switch-driven
//   requesters. Each debounced button pulse starts one arbitration. The winner
//   is the lowest requester at or above the rotating priority pointer, wrapping
//   to the lowest requester overall. A grant ends on a button press, when its
//   request drops, or after HOLD_CYCLES cycles, whichever comes first.
//
// Ports
//   clk_i            system clock
//   rstn_i           asynchronous active-low reset
//   req_i            request vector, bit k = requester k
//   btn_was_pressed  single-cycle pulse from the button debouncer
//   grant_o          one-hot registered grant, zero when idle
//   grant_idx_o      binary index of the current/last grant
//   busy_o           high while a grant is active
//   release_o        one-cycle pulse when a grant ends
//   cause_o          release reason: 01 timeout, 10 request dropped, 11 button
//
// state | meaning
// IDLE  | no grant held; a button press with any request arbitrates
// GRANT | one requester holds the slot; watch button, request and timer
module rr_switch_arbiter #(
    parameter int N           = 10,
    parameter int HOLD_CYCLES = 16,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N-1:0]     req_i,
    input  logic             btn_was_pressed,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             busy_o,
    output logic             release_o,
    output logic [1:0]       cause_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [1:0] CAUSE_TMO  = 2'b01;
    localparam logic [1:0] CAUSE_DROP = 2'b10;
    localparam logic [1:0] CAUSE_BTN  = 2'b11;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             rel_q, rel_d;
    logic [1:0]       cause_q, cause_d;

    logic [N-1:0]     low_mask;
    logic [N-1:0]     hi;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] sel_idx;

    // Requests at or above the pointer win first; x & -x isolates the
    // lowest set bit, and falling back to the full vector gives the wrap.
    always_comb begin
        low_mask = (N'(1) << ptr_q) - N'(1);
        hi       = req_i & ~low_mask;
        sel      = (hi != '0) ? (hi & (-hi)) : (req_i & (-req_i));
        sel_idx  = '0;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) sel_idx = IDX_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rel_d   = 1'b0;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (btn_was_pressed && (req_i != '0)) begin
                    grant_d = sel;
                    idx_d   = sel_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (btn_was_pressed || ((req_i & grant_q) == '0) ||
                    (cnt_q == CNT_W'(HOLD_CYCLES - 1))) begin
                    if (btn_was_pressed)               cause_d = CAUSE_BTN;
                    else if ((req_i & grant_q) == '0)  cause_d = CAUSE_DROP;
                    else                               cause_d = CAUSE_TMO;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    rel_d   = 1'b1;
                    ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rel_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rel_q   <= rel_d;
            cause_q <= cause_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = busy_q;
    assign release_o   = rel_q;
    assign cause_o     = cause_q;

endmodule
